// File: rtl/table_order_terminal_if.sv
// Signal bundle between a table order terminal and its environment (customer side,
// manager order channel, kitchen delivery and billing).
interface table_order_terminal_if;
  logic [1:0] req_item;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] order_item;
  logic       order_valid;
  logic       order_reject;
  logic       item_ready;
  logic [1:0] ready_item;
  logic       bill_clear;
  logic [7:0] bill;
  logic [3:0] outstanding;
  logic       drop_pulse;
  logic [1:0] dropped_item;
  logic       spurious;

  modport slave (
    input  req_item, req_valid, order_reject, item_ready, ready_item, bill_clear,
    output req_ready, order_item, order_valid, bill, outstanding, drop_pulse, dropped_item,
           spurious
  );

  modport master (
    output req_item, req_valid, order_reject, item_ready, ready_item, bill_clear,
    input  req_ready, order_item, order_valid, bill, outstanding, drop_pulse, dropped_item,
           spurious
  );
endinterface

// File: rtl/table_order_terminal.sv
// Per-table ordering client: FIFO of customer requests, one order attempt at a time with
// reject retry/back-off/drop, and delivery-driven outstanding count and saturating bill.
module table_order_terminal #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned BACKOFF_CYC = 2,
  parameter logic [7:0]  PRICE0      = 8'd10,
  parameter logic [7:0]  PRICE1      = 8'd15,
  parameter logic [7:0]  PRICE2      = 8'd20,
  parameter logic [7:0]  PRICE3      = 8'd25
) (
  input logic                   clk,
  input logic                   reset,
  table_order_terminal_if.slave bus
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]  TryLast = 4'(MAX_TRIES - 1);
  localparam logic [3:0]  BoLast  = 4'((BACKOFF_CYC == 0) ? 0 : BACKOFF_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSend, StBackoff} state_e;

  state_e          state_q, state_d;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      tries_q, tries_d;
  logic [3:0]      bo_cnt_q, bo_cnt_d;
  logic [3:0]      outstanding_q, outstanding_d;
  logic [7:0]      bill_q, bill_d;
  logic            drop_q, drop_d;
  logic [1:0]      dropped_item_q, dropped_item_d;
  logic            spurious_q;
  logic            req_ready, push, pop, accept, deliver;
  logic [1:0]      head;
  logic [7:0]      price;
  logic [8:0]      bill_sum;

  assign req_ready = (count_q < CntW'(FIFO_DEPTH));
  assign push      = bus.req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];
  assign deliver   = bus.item_ready && (outstanding_q != 4'd0);

  // The head is only popped on accept or drop, so it stays put across retries.
  always_comb begin
    state_d        = state_q;
    tries_d        = tries_q;
    bo_cnt_d       = bo_cnt_q;
    accept         = 1'b0;
    pop            = 1'b0;
    drop_d         = 1'b0;
    dropped_item_d = dropped_item_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && outstanding_q != 4'd15) begin
          state_d = StSend;
          tries_d = 4'd0;
        end
      end
      StSend: begin
        if (!bus.order_reject) begin
          accept  = 1'b1;
          pop     = 1'b1;
          state_d = StIdle;
        end else if (tries_q < TryLast) begin
          tries_d  = tries_q + 4'd1;
          bo_cnt_d = 4'd0;
          state_d  = (BACKOFF_CYC == 0) ? StSend : StBackoff;
        end else begin
          pop            = 1'b1;
          drop_d         = 1'b1;
          dropped_item_d = head;
          state_d        = StIdle;
        end
      end
      StBackoff: begin
        if (bo_cnt_q == BoLast) begin
          state_d = StSend;
        end else begin
          bo_cnt_d = bo_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    price = PRICE0;
    unique case (bus.ready_item)
      2'd0: price = PRICE0;
      2'd1: price = PRICE1;
      2'd2: price = PRICE2;
      2'd3: price = PRICE3;
      default: price = PRICE0;
    endcase
  end

  assign bill_sum = {1'b0, bill_q} + {1'b0, price};

  always_comb begin
    bill_d        = bill_q;
    outstanding_d = outstanding_q;
    if (bus.bill_clear) begin
      bill_d = deliver ? price : 8'd0;
    end else if (deliver) begin
      bill_d = bill_sum[8] ? 8'hFF : bill_sum[7:0];
    end
    if (accept && !deliver) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (deliver && !accept) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      tries_q        <= 4'd0;
      bo_cnt_q       <= 4'd0;
      outstanding_q  <= 4'd0;
      bill_q         <= 8'd0;
      drop_q         <= 1'b0;
      dropped_item_q <= 2'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      tries_q        <= tries_d;
      bo_cnt_q       <= bo_cnt_d;
      outstanding_q  <= outstanding_d;
      bill_q         <= bill_d;
      drop_q         <= drop_d;
      dropped_item_q <= dropped_item_d;
      spurious_q     <= bus.item_ready && (outstanding_q == 4'd0);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.req_item;
  end

  assign bus.req_ready    = req_ready;
  assign bus.order_valid  = (state_q == StSend);
  assign bus.order_item   = (state_q == StSend) ? head : 2'd0;
  assign bus.bill         = bill_q;
  assign bus.outstanding  = outstanding_q;
  assign bus.drop_pulse   = drop_q;
  assign bus.dropped_item = dropped_item_q;
  assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_table_order_terminal.sv
// Bench for table_order_terminal: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based transaction model of the terminal.
module tb_table_order_terminal;

  localparam int Depth   = 4;
  localparam int Tries   = 3;
  localparam int Backoff = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  table_order_terminal_if bus();

  table_order_terminal #(
    .FIFO_DEPTH (Depth),
    .MAX_TRIES  (Tries),
    .BACKOFF_CYC(Backoff)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model state (values as seen at the start of the current cycle).
  int m_fifo[$];
  int m_out = 0;
  int m_bill = 0;
  int m_tries = 0;
  int m_last_rej = 0;
  int m_stall = 0;
  int m_drop_item = 0;
  bit m_drop_exp = 0;
  bit m_spur_exp = 0;
  bit mon_en = 0;
  bit just_reset = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int price_of(input int id);
    case (id)
      0: return 10;
      1: return 15;
      2: return 20;
      default: return 25;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the model, then advance the model by one cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("req_ready", int'(bus.req_ready), int'(m_fifo.size() < Depth));
      check("bill", int'(bus.bill), m_bill);
      check("outstanding", int'(bus.outstanding), m_out);
      check("drop_pulse", int'(bus.drop_pulse), int'(m_drop_exp));
      if (m_drop_exp) check("dropped_item", int'(bus.dropped_item), m_drop_item);
      check("spurious", int'(bus.spurious), int'(m_spur_exp));
      if (just_reset) begin
        check("reset_order_valid", int'(bus.order_valid), 0);
        check("reset_order_item", int'(bus.order_item), 0);
        check("reset_dropped_item", int'(bus.dropped_item), 0);
      end
      if (bus.order_valid) begin
        if (m_fifo.size() == 0) begin
          check("order_valid_with_empty_queue", int'(bus.order_valid), 0);
        end else begin
          check("order_item", int'(bus.order_item), m_fifo[0]);
          if (m_tries > 0) check("retry_spacing", cyc - m_last_rej, Backoff + 1);
        end
      end
      if (m_fifo.size() > 0 && m_out < 15 && !bus.order_valid) m_stall++;
      else m_stall = 0;
      if (m_stall > ((Backoff > 1) ? Backoff : 1)) begin
        check("order_stall", m_stall, (Backoff > 1) ? Backoff : 1);
        m_stall = 0;
      end
    end

    if (reset == 1'b0) begin
      mon_en     = 1;
      just_reset = 1;
      m_fifo.delete();
      m_out      = 0;
      m_bill     = 0;
      m_tries    = 0;
      m_stall    = 0;
      m_drop_exp = 0;
      m_spur_exp = 0;
    end else if (mon_en) begin
      bit push_ok;
      bit del;
      int acc;
      just_reset = 0;
      push_ok    = bus.req_valid && (m_fifo.size() < Depth);
      del        = bus.item_ready && (m_out > 0);
      acc        = 0;
      m_drop_exp = 0;
      m_spur_exp = bus.item_ready && (m_out == 0);
      if (bus.order_valid && m_fifo.size() > 0) begin
        if (!bus.order_reject) begin
          void'(m_fifo.pop_front());
          acc     = 1;
          m_tries = 0;
        end else begin
          m_tries++;
          m_last_rej = cyc;
          if (m_tries >= Tries) begin
            m_drop_item = m_fifo.pop_front();
            m_drop_exp  = 1;
            m_tries     = 0;
          end
        end
      end
      if (push_ok) m_fifo.push_back(int'(bus.req_item));
      if (bus.bill_clear) m_bill = del ? price_of(int'(bus.ready_item)) : 0;
      else if (del) begin
        m_bill = m_bill + price_of(int'(bus.ready_item));
        if (m_bill > 255) m_bill = 255;
      end
      m_out = m_out + acc - int'(del);
    end
  end

  task automatic wait_out(input int n);
    int k = 0;
    while (int'(bus.outstanding) != n && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wait_outstanding", int'(bus.outstanding), n);
  endtask

  task automatic deliver(input int item, input int n);
    for (int i = 0; i < n; i++) begin
      bus.item_ready = 1'b1;
      bus.ready_item = 2'(item);
      tick();
    end
    bus.item_ready = 1'b0;
  endtask

  task automatic push_one(input int item);
    bus.req_valid = 1'b1;
    bus.req_item  = 2'(item);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int got[$];
    int exp_seq[4];
    int valids;
    int drops;
    int pushed;
    int k;

    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_item     = 2'd0;
    bus.order_reject = 1'b0;
    bus.item_ready   = 1'b0;
    bus.ready_item   = 2'd0;
    bus.bill_clear   = 1'b0;
    repeat (2) tick();
    check("reset_req_ready", int'(bus.req_ready), 1);
    check("reset_bill", int'(bus.bill), 0);
    reset = 1'b1;

    // Basic flow: push item 2, order at t+2, outstanding at t+3, delivery bills 20.
    push_one(2);
    @(negedge clk);
    check("latency_t1_idle", int'(bus.order_valid), 0);
    @(negedge clk);
    check("latency_t2_valid", int'(bus.order_valid), 1);
    check("latency_t2_item", int'(bus.order_item), 2);
    @(negedge clk);
    check("basic_outstanding", int'(bus.outstanding), 1);
    tick();
    deliver(2, 1);
    @(negedge clk);
    check("basic_bill", int'(bus.bill), 20);
    check("basic_out_zero", int'(bus.outstanding), 0);

    // FIFO full under rejects, then in-order issue.
    tick();
    bus.order_reject = 1'b1;
    exp_seq = '{3, 0, 1, 2};
    for (int i = 0; i < 4; i++) push_one(exp_seq[i]);
    @(negedge clk);
    check("fifo_full_ready", int'(bus.req_ready), 0);
    tick();
    bus.order_reject = 1'b0;
    k = 0;
    while (got.size() < 4 && k < 40) begin
      @(negedge clk);
      if (bus.order_valid) got.push_back(int'(bus.order_item));
      k++;
    end
    check("fifo_order_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("fifo_order_seq", got[i], exp_seq[i]);
    wait_out(4);
    tick();
    deliver(0, 4);
    @(negedge clk);
    check("bill_after_fifo", int'(bus.bill), 60);

    // Retry and drop: three attempts on item 1, then a single drop pulse.
    tick();
    bus.order_reject = 1'b1;
    push_one(1);
    valids = 0;
    drops  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.order_valid) valids++;
      if (bus.drop_pulse) begin
        drops++;
        check("drop_item_id", int'(bus.dropped_item), 1);
      end
    end
    check("drop_attempts", valids, 3);
    check("drop_pulses", drops, 1);
    check("drop_out_zero", int'(bus.outstanding), 0);
    tick();
    bus.order_reject = 1'b0;

    // Accept and delivery in the same cycle; then a spurious delivery.
    push_one(0);
    wait_out(1);
    tick();
    push_one(1);
    k = 0;
    while (!bus.order_valid && k < 10) begin
      tick();
      k++;
    end
    check("simul_order_seen", int'(bus.order_valid), 1);
    bus.item_ready = 1'b1;
    bus.ready_item = 2'd3;
    tick();
    bus.item_ready = 1'b0;
    @(negedge clk);
    check("simul_outstanding", int'(bus.outstanding), 1);
    check("simul_bill", int'(bus.bill), 85);
    tick();
    bus.item_ready = 1'b1;
    bus.ready_item = 2'd2;
    tick();
    bus.ready_item = 2'd1;
    tick();
    bus.item_ready = 1'b0;
    @(negedge clk);
    check("spurious_pulse", int'(bus.spurious), 1);
    check("spurious_bill", int'(bus.bill), 105);
    @(negedge clk);
    check("spurious_one_cycle", int'(bus.spurious), 0);

    // Saturation and clear.
    tick();
    pushed = 0;
    for (int i = 0; i < 80 && pushed < 12; i++) begin
      bus.req_valid = 1'b1;
      bus.req_item  = 2'd3;
      if (bus.req_ready) pushed++;
      tick();
    end
    bus.req_valid = 1'b0;
    wait_out(12);
    tick();
    deliver(3, 11);
    @(negedge clk);
    check("bill_saturated", int'(bus.bill), 255);
    tick();
    bus.bill_clear = 1'b1;
    deliver(0, 1);
    bus.bill_clear = 1'b0;
    @(negedge clk);
    check("clear_with_delivery", int'(bus.bill), 10);
    tick();
    bus.bill_clear = 1'b1;
    tick();
    bus.bill_clear = 1'b0;
    @(negedge clk);
    check("clear_alone", int'(bus.bill), 0);

    // Mid-operation reset during back-off with 3 queued and 2 outstanding.
    tick();
    push_one(0);
    push_one(1);
    wait_out(2);
    tick();
    bus.order_reject = 1'b1;
    push_one(1);
    push_one(2);
    push_one(3);
    k = 0;
    while (!bus.order_valid && k < 10) begin
      tick();
      k++;
    end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.order_reject = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", int'(bus.req_ready), 1);
    check("midrst_outstanding", int'(bus.outstanding), 0);
    check("midrst_order_valid", int'(bus.order_valid), 0);
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.drop_pulse) drops++;
    end
    check("midrst_no_drop", drops, 0);

    // Random traffic against the model.
    tick();
    for (int i = 0; i < 2000; i++) begin
      reset            = ($urandom_range(0, 599) != 0);
      bus.req_valid    = ($urandom_range(0, 99) < 40);
      bus.req_item     = 2'($urandom_range(0, 3));
      bus.order_reject = ($urandom_range(0, 99) < 35);
      bus.item_ready   = ($urandom_range(0, 99) < 30);
      bus.ready_item   = 2'($urandom_range(0, 3));
      bus.bill_clear   = ($urandom_range(0, 99) < 3);
      tick();
    end
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.order_reject = 1'b0;
    bus.item_ready   = 1'b0;
    bus.bill_clear   = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
